alarm_bank: RTL and testbench
=============================

Name: alarm_bank

Overview:
- Parametrised successor to the single-word alarm store. Holds NUM_ALARMS alarm times with per-slot arm bits.
- Compares the armed slots against the running clock time once per minute tick.
- Drives a ringing / snoozed / idle state machine that the buzzer and display logic consume.
- Sits between the switch/button decode logic and the alarm output / puzzle-dismiss logic.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (≥1).
- TIME_W, 14, width of a time word; compared by exact equality, no format interpretation.
- SNOOZE_MIN, 5, minute ticks spent in SNOOZED before ringing again (≥1).
- RING_MIN, 10, minute ticks of ringing before automatic stop (≥1).
- AW, $clog2(NUM_ALARMS) (min 1), slot address width (derived).

Ports:
- clk  in  1  system clock (100 MHz board clock)
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write wr_data into slot wr_addr this cycle
- wr_addr  in  AW  slot written
- wr_data  in  TIME_W  alarm time to store
- arm_en  in  1  write arm_val into the arm bit of slot wr_addr this cycle
- arm_val  in  1  new arm bit
- rd_addr  in  AW  slot read
- read_data  out  TIME_W  stored time of rd_addr, registered
- cur_time  in  TIME_W  current clock time; valid in any cycle where min_tick=1
- min_tick  in  1  one-cycle pulse per minute boundary
- dismiss  in  1  one-cycle pulse: stop alarm
- snooze  in  1  one-cycle pulse: snooze alarm
- armed  out  NUM_ALARMS  arm bit per slot
- alarm_active  out  1  high while in RINGING
- snoozed  out  1  high while in SNOOZED
- active_slot  out  AW  slot that caused the current ring

Behaviour:
- Reset: all slot times 0; armed 0; read_data 0; state IDLE; alarm_active 0; snoozed 0; active_slot 0; counters 0.
- Storage writes take effect at the clock edge.
- wr_en and arm_en may both be asserted in one cycle; both apply to wr_addr.
- wr_addr ≥ NUM_ALARMS: write ignored.
- Read: read_data is valid 1 cycle after rd_addr.
- Read-during-write to the same slot returns the old value (read-before-write). The new value is visible on the following read.
- rd_addr ≥ NUM_ALARMS returns 0.
- Match: only in a cycle with min_tick=1. A slot matches when its arm bit is 1 and its time == cur_time. Arm/time values used are those registered before this edge.
- Multiple matches: the lowest slot index wins.
- FSM states IDLE, RINGING, SNOOZED.
- IDLE:
  - Match → RINGING next cycle.
  - On that transition: active_slot ← winning index; ring counter ← RING_MIN.
- RINGING:
  - dismiss → IDLE.
  - Else snooze → SNOOZED, snooze counter ← SNOOZE_MIN.
  - Else min_tick: ring counter decrements; the tick that takes it to 0 → IDLE.
  - New matches are ignored.
- SNOOZED:
  - dismiss → IDLE.
  - Else min_tick: snooze counter decrements; the tick that takes it to 0 → RINGING, ring counter ← RING_MIN.
  - snooze is ignored.
- Priority within a cycle: rst > dismiss > snooze > disarm of active_slot > min_tick events.
- Disarming active_slot (arm_en=1, arm_val=0, wr_addr=active_slot) in RINGING or SNOOZED → IDLE.
- Rewriting the time of active_slot does not change the state.
- After returning to IDLE, the same slot re-triggers only at its next matching min_tick; no re-trigger within the same minute.
- alarm_active = (state == RINGING). snoozed = (state == SNOOZED). Both are registered, with no combinational path from inputs.
- active_slot holds its last value in IDLE.
- Counters saturate: they never wrap below 0.

Test Plan:
- Reset check: rst for 2 cycles → read_data=0, armed=0, alarm_active=0, snoozed=0. Write slot 1 = 14'h0730, rd_addr=1 → read_data=14'h0730 one cycle later.
- Match trigger: arm slot 2 = 14'h0615, min_tick with cur_time=14'h0615 → alarm_active=1 next cycle, active_slot=2. min_tick with cur_time=14'h0614 on a disarmed slot → no ring.
- Priority: slots 0 and 3 both armed at 14'h0800, tick at 14'h0800 → active_slot=0. Dismiss and snooze in the same cycle → IDLE.
- Snooze: ringing, snooze pulse → snoozed=1. 4 ticks → still snoozed. 5th tick → alarm_active=1, snoozed=0.
- Auto-stop: ringing with no input → exactly 10 min_ticks → IDLE. Disarm active_slot mid-ring → IDLE next cycle.
- Read-during-write: slot 0 holds 14'h0100; write 14'h0200 with rd_addr=0 in the same cycle → read_data=14'h0100. Next cycle → 14'h0200.

Source files
------------

// File: rtl/alarm_bank.sv
// Multi-slot alarm store with per-slot arm bits. On each minute tick the armed
// slots are compared with the clock time and a ringing/snoozed/idle FSM is driven.
module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int TIME_W     = 14,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 10,
    parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [TIME_W-1:0]     wr_data,
    input  logic                  arm_en,
    input  logic                  arm_val,
    input  logic [AW-1:0]         rd_addr,
    output logic [TIME_W-1:0]     read_data,
    input  logic [TIME_W-1:0]     cur_time,
    input  logic                  min_tick,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic [NUM_ALARMS-1:0] armed,
    output logic                  alarm_active,
    output logic                  snoozed,
    output logic [AW-1:0]         active_slot
);

    localparam int RCW = $clog2(RING_MIN + 1);
    localparam int SCW = $clog2(SNOOZE_MIN + 1);
    localparam logic [AW:0]    NA         = (AW + 1)'(NUM_ALARMS);
    localparam logic [RCW-1:0] RING_INIT  = RCW'(RING_MIN);
    localparam logic [SCW-1:0] SNZ_INIT   = SCW'(SNOOZE_MIN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZED = 2'd2
    } state_t;

    logic [TIME_W-1:0]     r_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_armed;
    logic [TIME_W-1:0]     r_rd_data;
    state_t                r_state;
    logic [RCW-1:0]        r_ring;
    logic [SCW-1:0]        r_snz;
    logic [AW-1:0]         r_slot;
    logic                  r_alarm_active;
    logic                  r_snoozed;

    state_t                w_state_nxt;
    logic [RCW-1:0]        w_ring_nxt;
    logic [SCW-1:0]        w_snz_nxt;
    logic [AW-1:0]         w_slot_nxt;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_hit;
    logic [AW-1:0]         w_hit_idx;
    logic                  w_disarm;

    assign w_wr_ok  = ({1'b0, wr_addr} < NA);
    assign w_rd_ok  = ({1'b0, rd_addr} < NA);
    assign w_disarm = arm_en && !arm_val && w_wr_ok && (wr_addr == r_slot);

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        if (min_tick) begin
            for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
                if (r_armed[i] && (r_time[i] == cur_time)) begin
                    w_hit     = 1'b1;
                    w_hit_idx = AW'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring;
        w_snz_nxt   = r_snz;
        w_slot_nxt  = r_slot;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = S_RINGING;
                    w_slot_nxt  = w_hit_idx;
                    w_ring_nxt  = RING_INIT;
                end
            end
            S_RINGING: begin
                if (dismiss) begin
                    w_state_nxt = S_IDLE;
                end else if (snooze) begin
                    w_state_nxt = S_SNOOZED;
                    w_snz_nxt   = SNZ_INIT;
                end else if (w_disarm) begin
                    w_state_nxt = S_IDLE;
                end else if (min_tick) begin
                    if (r_ring <= RCW'(1)) begin
                        w_ring_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ring_nxt = r_ring - RCW'(1);
                    end
                end
            end
            S_SNOOZED: begin
                if (dismiss || w_disarm) begin
                    w_state_nxt = S_IDLE;
                end else if (min_tick) begin
                    if (r_snz <= SCW'(1)) begin
                        w_snz_nxt   = '0;
                        w_state_nxt = S_RINGING;
                        w_ring_nxt  = RING_INIT;
                    end else begin
                        w_snz_nxt = r_snz - SCW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_ring         <= '0;
            r_snz          <= '0;
            r_slot         <= '0;
            r_alarm_active <= 1'b0;
            r_snoozed      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ring         <= w_ring_nxt;
            r_snz          <= w_snz_nxt;
            r_slot         <= w_slot_nxt;
            r_alarm_active <= (w_state_nxt == S_RINGING);
            r_snoozed      <= (w_state_nxt == S_SNOOZED);
        end
    end

    // Read samples the pre-edge contents, giving read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) r_time[i] <= '0;
            r_armed   <= '0;
            r_rd_data <= '0;
        end else begin
            if (wr_en && w_wr_ok) r_time[wr_addr] <= wr_data;
            if (arm_en && w_wr_ok) r_armed[wr_addr] <= arm_val;
            r_rd_data <= w_rd_ok ? r_time[rd_addr] : '0;
        end
    end

    assign read_data    = r_rd_data;
    assign armed        = r_armed;
    assign alarm_active = r_alarm_active;
    assign snoozed      = r_snoozed;
    assign active_slot  = r_slot;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed testbench for alarm_bank: storage, matching, priority, snooze,
// auto-stop, disarm and read-during-write.
module tb_alarm_bank;

    localparam int NA = 4;
    localparam int TW = 14;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_data;
    logic          arm_en;
    logic          arm_val;
    logic [AW-1:0] rd_addr;
    logic [TW-1:0] read_data;
    logic [TW-1:0] cur_time;
    logic          min_tick;
    logic          dismiss;
    logic          snooze;
    logic [NA-1:0] armed;
    logic          alarm_active;
    logic          snoozed;
    logic [AW-1:0] active_slot;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alarm_bank #(.NUM_ALARMS(NA), .TIME_W(TW), .SNOOZE_MIN(5), .RING_MIN(10)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .arm_en(arm_en), .arm_val(arm_val), .rd_addr(rd_addr), .read_data(read_data),
        .cur_time(cur_time), .min_tick(min_tick), .dismiss(dismiss), .snooze(snooze),
        .armed(armed), .alarm_active(alarm_active), .snoozed(snoozed),
        .active_slot(active_slot)
    );

    // One-cycle storage write; inputs change on negedge, away from the active edge.
    task automatic wr(input logic [AW-1:0] a, input logic [TW-1:0] d,
                      input logic we, input logic ae, input logic av);
        @(negedge clk);
        wr_en = we; wr_addr = a; wr_data = d; arm_en = ae; arm_val = av;
        @(negedge clk);
        wr_en = 1'b0; arm_en = 1'b0;
    endtask

    task automatic tick(input logic [TW-1:0] t);
        @(negedge clk);
        min_tick = 1'b1; cur_time = t;
        @(negedge clk);
        min_tick = 1'b0;
    endtask

    task automatic pulse(input logic dis, input logic snz);
        @(negedge clk);
        dismiss = dis; snooze = snz;
        @(negedge clk);
        dismiss = 1'b0; snooze = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (read_data !== 14'h0) begin n_err++; $display("FAIL reset_read_data: got %h want 0", read_data); end
        n_cmp++; if (armed !== 4'b0) begin n_err++; $display("FAIL reset_armed: got %b want 0000", armed); end
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL reset_alarm_active: got %b want 0", alarm_active); end
        n_cmp++; if (snoozed !== 1'b0) begin n_err++; $display("FAIL reset_snoozed: got %b want 0", snoozed); end
        n_cmp++; if (active_slot !== 2'd0) begin n_err++; $display("FAIL reset_active_slot: got %0d want 0", active_slot); end
        wr(2'd1, 14'h0730, 1'b1, 1'b0, 1'b0);
        rd_addr = 2'd1;
        @(negedge clk);
        n_cmp++; if (read_data !== 14'h0730) begin n_err++; $display("FAIL write_read_slot1: got %h want 0730", read_data); end
    endtask

    task automatic test_match;
        wr(2'd2, 14'h0615, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (armed !== 4'b0100) begin n_err++; $display("FAIL arm_slot2: got %b want 0100", armed); end
        tick(14'h0615);
        n_cmp++; if (alarm_active !== 1'b1) begin n_err++; $display("FAIL match_ring: got %b want 1", alarm_active); end
        n_cmp++; if (active_slot !== 2'd2) begin n_err++; $display("FAIL match_slot: got %0d want 2", active_slot); end
        pulse(1'b1, 1'b0);
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL dismiss_stop: got %b want 0", alarm_active); end
        n_cmp++; if (active_slot !== 2'd2) begin n_err++; $display("FAIL idle_hold_slot: got %0d want 2", active_slot); end
        // Unarmed slot 1 at 0614 and disarmed slot 2 at 0615 must both stay silent.
        wr(2'd1, 14'h0614, 1'b1, 1'b0, 1'b0);
        wr(2'd2, 14'h0615, 1'b0, 1'b1, 1'b0);
        tick(14'h0614);
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL unarmed_no_ring: got %b want 0", alarm_active); end
        tick(14'h0615);
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL disarmed_no_ring: got %b want 0", alarm_active); end
        // Matching cur_time without a tick must not ring.
        @(negedge clk); cur_time = 14'h0730; wr(2'd1, 14'h0730, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL no_tick_no_ring: got %b want 0", alarm_active); end
        wr(2'd1, 14'h0730, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_priority;
        wr(2'd0, 14'h0800, 1'b1, 1'b1, 1'b1);
        wr(2'd3, 14'h0800, 1'b1, 1'b1, 1'b1);
        tick(14'h0800);
        n_cmp++; if (alarm_active !== 1'b1) begin n_err++; $display("FAIL prio_ring: got %b want 1", alarm_active); end
        n_cmp++; if (active_slot !== 2'd0) begin n_err++; $display("FAIL prio_lowest_slot: got %0d want 0", active_slot); end
        pulse(1'b1, 1'b1);
        n_cmp++; if (alarm_active !== 1'b0 || snoozed !== 1'b0) begin
            n_err++; $display("FAIL dismiss_over_snooze: got active=%b snoozed=%b want 0 0", alarm_active, snoozed); end
    endtask

    task automatic test_snooze;
        tick(14'h0800);
        pulse(1'b0, 1'b1);
        n_cmp++; if (snoozed !== 1'b1 || alarm_active !== 1'b0) begin
            n_err++; $display("FAIL snooze_enter: got active=%b snoozed=%b want 0 1", alarm_active, snoozed); end
        for (int i = 1; i <= 4; i++) tick(14'h0800 + TW'(i));
        n_cmp++; if (snoozed !== 1'b1) begin n_err++; $display("FAIL snooze_after4: got %b want 1", snoozed); end
        tick(14'h0805);
        n_cmp++; if (alarm_active !== 1'b1 || snoozed !== 1'b0) begin
            n_err++; $display("FAIL snooze_rering: got active=%b snoozed=%b want 1 0", alarm_active, snoozed); end
        pulse(1'b1, 1'b0);
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL snooze_dismiss: got %b want 0", alarm_active); end
    endtask

    task automatic test_autostop;
        tick(14'h0800);
        for (int i = 0; i < 9; i++) tick(14'h0900 + TW'(i));
        n_cmp++; if (alarm_active !== 1'b1) begin n_err++; $display("FAIL ring_after9: got %b want 1", alarm_active); end
        tick(14'h0909);
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL autostop_10: got %b want 0", alarm_active); end
        tick(14'h0800);
        n_cmp++; if (alarm_active !== 1'b1) begin n_err++; $display("FAIL rering: got %b want 1", alarm_active); end
        wr(2'd3, 14'h0800, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (alarm_active !== 1'b1) begin n_err++; $display("FAIL disarm_other_keeps: got %b want 1", alarm_active); end
        wr(2'd0, 14'h0123, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (alarm_active !== 1'b1) begin n_err++; $display("FAIL rewrite_active_keeps: got %b want 1", alarm_active); end
        wr(2'd0, 14'h0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (alarm_active !== 1'b0) begin n_err++; $display("FAIL disarm_active_stop: got %b want 0", alarm_active); end
        n_cmp++; if (armed !== 4'b0000) begin n_err++; $display("FAIL armed_final: got %b want 0000", armed); end
    endtask

    task automatic test_rdw;
        wr(2'd0, 14'h0100, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 14'h0200; rd_addr = 2'd0;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (read_data !== 14'h0100) begin n_err++; $display("FAIL rdw_old: got %h want 0100", read_data); end
        @(negedge clk);
        n_cmp++; if (read_data !== 14'h0200) begin n_err++; $display("FAIL rdw_new: got %h want 0200", read_data); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; arm_en = 1'b0; arm_val = 1'b0;
        rd_addr = '0; cur_time = '0; min_tick = 1'b0; dismiss = 1'b0; snooze = 1'b0;
        test_reset;
        test_match;
        test_priority;
        test_snooze;
        test_autostop;
        test_rdw;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
